// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, coordinate type and a window helper.
package vga_pkg;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;
   localparam int VGA_PIX_DIV   = 4;

   localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // True when lo <= v < hi.
   function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/hvsync_gen_if.sv
// Video timing bundle: pixel enable, scan coordinates and decoded syncs.
// All signals are produced by the generator (master) on clk_100 and are
// plain levels; there is no handshake, a consumer samples them whenever
// pix_tick is high.
interface hvsync_if;
   import vga_pkg::*;

   logic   pix_tick;
   coord_t pixel_x;
   coord_t pixel_y;
   logic   video_on;
   logic   hsync;
   logic   vsync;
   logic   frame_start;

   modport master (
      output pix_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
   );

   modport slave (
      input pix_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
   );

endinterface

// File: rtl/hvsync_gen_pix_div.sv
// Pixel-enable divider: counts 0..PIX_DIV-1, pulses pix_tick on the last count.
module pix_div
   import vga_pkg::*;
#(
   parameter int PIX_DIV = VGA_PIX_DIV
) (
   input  logic clk_100,
   input  logic rst,
   output logic pix_tick
);

   localparam int            DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;

   // Next divider value: wrap to zero after the last count.
   always_comb begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
   end

   // Divider register, cleared asynchronously so the first tick lands on
   // the PIX_DIV-th edge after release.
   always_ff @(posedge clk_100 or negedge rst) begin
      if (!rst) div_q <= '0;
      else      div_q <= div_d;
   end

   // Gated by rst so a PIX_DIV of 1 still reads 0 during reset.
   assign pix_tick = rst & (div_q == DIV_MAX);

endmodule

// File: rtl/hvsync_gen.sv
// VGA horizontal/vertical scan generator. Counters advance on pix_tick;
// syncs, video_on and frame_start are decoded from the next counter values
// and registered so they line up with the coordinates they describe.
module hvsync_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter int PIX_DIV   = VGA_PIX_DIV
) (
   input  logic      clk_100,
   input  logic      rst,
   hvsync_if.master  vid
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_MAX    = coord_t'(H_TOTAL - 1);
   localparam coord_t V_MAX    = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
   localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   logic   tick;
   coord_t x_q, x_d;
   coord_t y_q, y_d;
   logic   hsync_q, hsync_d;
   logic   vsync_q, vsync_d;
   logic   video_on_q, video_on_d;
   logic   frame_start_q, frame_start_d;

   pix_div #(
      .PIX_DIV (PIX_DIV)
   ) u_pix_div (
      .clk_100  (clk_100),
      .rst      (rst),
      .pix_tick (tick)
   );

   // Next scan position and the outputs decoded from it.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         if (x_q == H_MAX) begin
            x_d = '0;
            y_d = (y_q == V_MAX) ? '0 : y_q + coord_t'(1);
         end else begin
            x_d = x_q + coord_t'(1);
         end
      end
      hsync_d       = !in_window(x_d, HS_START, HS_END);
      vsync_d       = !in_window(y_d, VS_START, VS_END);
      video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
      frame_start_d = (x_d == '0) && (y_d == '0);
   end

   // Scan registers; reset values are the decode of pixel (0,0), so any
   // sync pulse in flight is dropped the moment rst falls.
   always_ff @(posedge clk_100 or negedge rst) begin
      if (!rst) begin
         x_q           <= '0;
         y_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b1;
         frame_start_q <= 1'b1;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vid.pix_tick    = tick;
   assign vid.pixel_x     = x_q;
   assign vid.pixel_y     = y_q;
   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.video_on    = video_on_q;
   assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_hvsync_gen.sv
// Directed bench: default 640x480 instance for line-level timing and a
// small 14x7 instance for frame-level wrap and vsync behaviour.
`timescale 1ns/1ps
module tb_hvsync_gen;

   logic clk = 1'b0;
   logic rst_d = 1'b0;
   logic rst_s = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   ed = 0;
   int   es = 0;
   int   cnt_a, cnt_b, cnt_c, cnt_d;

   hvsync_if vga_d ();
   hvsync_if vga_s ();

   hvsync_gen dut (
      .clk_100 (clk),
      .rst     (rst_d),
      .vid     (vga_d)
   );

   hvsync_gen #(
      .H_VISIBLE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .PIX_DIV   (4)
   ) dut_s (
      .clk_100 (clk),
      .rst     (rst_s),
      .vid     (vga_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the default instance to edge number t after its reset release.
   task automatic goto_d(input int t);
      repeat (t - ed) @(posedge clk);
      #1;
      ed = t;
   endtask

   task automatic goto_s(input int t);
      repeat (t - es) @(posedge clk);
      #1;
      es = t;
   endtask

   task automatic chk_reset_d(input string tag);
      chk({tag, "_tick"}, vga_d.pix_tick, 0);
      chk({tag, "_x"},    vga_d.pixel_x, 0);
      chk({tag, "_y"},    vga_d.pixel_y, 0);
      chk({tag, "_von"},  vga_d.video_on, 1);
      chk({tag, "_fs"},   vga_d.frame_start, 1);
      chk({tag, "_hs"},   vga_d.hsync, 1);
      chk({tag, "_vs"},   vga_d.vsync, 1);
   endtask

   task automatic chk_reset_s(input string tag);
      chk({tag, "_tick"}, vga_s.pix_tick, 0);
      chk({tag, "_x"},    vga_s.pixel_x, 0);
      chk({tag, "_y"},    vga_s.pixel_y, 0);
      chk({tag, "_von"},  vga_s.video_on, 1);
      chk({tag, "_fs"},   vga_s.frame_start, 1);
      chk({tag, "_hs"},   vga_s.hsync, 1);
      chk({tag, "_vs"},   vga_s.vsync, 1);
   endtask

   initial begin
      // ---- reset state, default instance
      #100;
      chk_reset_d("rst0");
      #200;
      rst_d = 1'b1;                      // released at t=300 ns, a falling edge
      ed = 0;

      // ---- first ticks
      goto_d(1);  chk("e1_tick", vga_d.pix_tick, 0); chk("e1_x", vga_d.pixel_x, 0);
      goto_d(3);  chk("e3_tick", vga_d.pix_tick, 1); chk("e3_x", vga_d.pixel_x, 0);
      goto_d(4);  chk("e4_tick", vga_d.pix_tick, 0); chk("e4_x", vga_d.pixel_x, 1);
                  chk("e4_fs", vga_d.frame_start, 0);
      goto_d(7);  chk("e7_tick", vga_d.pix_tick, 1);
      goto_d(8);  chk("e8_x", vga_d.pixel_x, 2);
      goto_d(12); chk("e12_x", vga_d.pixel_x, 3);

      // ---- video_on and hsync boundaries on line 0
      goto_d(2559); chk("x639", vga_d.pixel_x, 639); chk("von639", vga_d.video_on, 1);
      goto_d(2560); chk("x640", vga_d.pixel_x, 640); chk("von640", vga_d.video_on, 0);
      goto_d(2623); chk("x655", vga_d.pixel_x, 655); chk("hs655", vga_d.hsync, 1);
      goto_d(2624); chk("hs656", vga_d.hsync, 0);
      goto_d(3007); chk("x751", vga_d.pixel_x, 751); chk("hs751", vga_d.hsync, 0);
      goto_d(3008); chk("hs752", vga_d.hsync, 1);
      goto_d(3199); chk("x799", vga_d.pixel_x, 799); chk("y_l0", vga_d.pixel_y, 0);
      goto_d(3200); chk("xwrap", vga_d.pixel_x, 0); chk("y_l1", vga_d.pixel_y, 1);
                    chk("von_l1", vga_d.video_on, 1); chk("fs_l1", vga_d.frame_start, 0);
                    chk("vs_l1", vga_d.vsync, 1);

      // ---- one full line of line 1
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 3200; i++) begin
         @(posedge clk); #1;
         if (!vga_d.hsync)   cnt_a++;
         if (vga_d.pix_tick) cnt_b++;
         if (vga_d.video_on) cnt_c++;
      end
      ed = 6400;
      chk("line_hs_low", cnt_a, 384);
      chk("line_ticks", cnt_b, 800);
      chk("line_von", cnt_c, 2560);
      chk("y_l2", vga_d.pixel_y, 2);

      // ---- asynchronous reset in the middle of an hsync pulse
      goto_d(9200); chk("mid_x", vga_d.pixel_x, 700); chk("mid_hs", vga_d.hsync, 0);
      rst_d = 1'b0;
      #2;                                // still well before the next edge
      chk_reset_d("arst");
      repeat (3) @(negedge clk);
      chk_reset_d("hold");
      rst_d = 1'b1;
      ed = 0;
      goto_d(3); chk("r3_tick", vga_d.pix_tick, 1); chk("r3_x", vga_d.pixel_x, 0);
      goto_d(4); chk("r4_x", vga_d.pixel_x, 1); chk("r4_y", vga_d.pixel_y, 0);

      // ---- small instance: 14 x 7 raster
      chk_reset_s("srst");
      @(negedge clk);
      rst_s = 1'b1;
      es = 0;
      goto_s(39);  chk("s_x9", vga_s.pixel_x, 9); chk("s_hs9", vga_s.hsync, 1);
      goto_s(40);  chk("s_hs10", vga_s.hsync, 0); chk("s_von10", vga_s.video_on, 0);
      goto_s(47);  chk("s_hs11", vga_s.hsync, 0);
      goto_s(48);  chk("s_hs12", vga_s.hsync, 1);
      goto_s(52);  chk("s_x13", vga_s.pixel_x, 13);
      goto_s(56);  chk("s_xw", vga_s.pixel_x, 0); chk("s_y1", vga_s.pixel_y, 1);
      goto_s(279); chk("s_y4", vga_s.pixel_y, 4); chk("s_vs4", vga_s.vsync, 1);
                   chk("s_von_y4", vga_s.video_on, 0);
      goto_s(280); chk("s_y5", vga_s.pixel_y, 5); chk("s_vs5", vga_s.vsync, 0);
      goto_s(336); chk("s_y6", vga_s.pixel_y, 6); chk("s_vs6", vga_s.vsync, 1);
      goto_s(391); chk("s_end_x", vga_s.pixel_x, 13); chk("s_end_y", vga_s.pixel_y, 6);
                   chk("s_end_fs", vga_s.frame_start, 0);
      goto_s(392); chk("s_fw_x", vga_s.pixel_x, 0); chk("s_fw_y", vga_s.pixel_y, 0);
                   chk("s_fw_fs", vga_s.frame_start, 1);

      // ---- one full small frame
      cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
      for (int i = 0; i < 392; i++) begin
         @(posedge clk); #1;
         if (!vga_s.vsync)      cnt_a++;
         if (!vga_s.hsync)      cnt_b++;
         if (vga_s.video_on)    cnt_c++;
         if (vga_s.frame_start) cnt_d++;
      end
      es = 784;
      chk("s_vs_low", cnt_a, 56);
      chk("s_hs_low", cnt_b, 56);
      chk("s_von", cnt_c, 128);
      chk("s_fs", cnt_d, 4);

      // ---- asynchronous reset during vsync
      goto_s(1076); chk("s_mid_x", vga_s.pixel_x, 3); chk("s_mid_y", vga_s.pixel_y, 5);
                    chk("s_mid_vs", vga_s.vsync, 0);
      rst_s = 1'b0;
      #2;
      chk_reset_s("s_arst");
      repeat (2) @(negedge clk);
      rst_s = 1'b1;
      es = 0;
      goto_s(4); chk("s_r4_x", vga_s.pixel_x, 1); chk("s_r4_y", vga_s.pixel_y, 0);
                 chk("s_r4_vs", vga_s.vsync, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hvsync_gen.md
HVSYNC_GEN -- requirements
Module: hvsync_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_VISIBLE 640 active pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_VISIBLE 480 active lines; V_FP 10; V_SYNC 2; V_BP 33; PIX_DIV 4 clk_100 cycles per pixel.
REQ-002 clk_100  input  1  the only clock, 100 MHz; all state on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 pix_tick  output  1  one-clk_100 pulse, once every PIX_DIV cycles; pixel enable.
REQ-005 pixel_x  output  10  horizontal count, 0..H_TOTAL-1.
REQ-006 pixel_y  output  10  vertical count, 0..V_TOTAL-1.
REQ-007 video_on  output  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
REQ-008 hsync  output  1  horizontal sync, active-low.
REQ-009 vsync  output  1  vertical sync, active-low.
REQ-010 frame_start  output  1  one-pix_tick-wide pulse at pixel (0,0).

Function
REQ-011 H_TOTAL SHALL be H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL be V_VISIBLE+V_FP+V_SYNC+V_BP (525).
REQ-012 A divider counter SHALL count 0..PIX_DIV-1 and wrap; pix_tick SHALL be high exactly on the cycles where the divider equals PIX_DIV-1.
REQ-013 pixel_x SHALL increment only on pix_tick, and SHALL wrap from H_TOTAL-1 to 0 on that same pix_tick.
REQ-014 pixel_y SHALL increment only on a pix_tick on which pixel_x wraps.
REQ-015 pixel_y SHALL wrap from V_TOTAL-1 to 0 when pixel_x and pixel_y wrap simultaneously.
REQ-016 hsync, vsync, video_on and frame_start SHALL be registered, with next values decoded from the next counter values, so each output is aligned with the pixel_x/pixel_y it describes (zero relative latency, no combinational output path).
REQ-017 hsync SHALL be low iff H_VISIBLE+H_FP <= pixel_x < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-018 vsync SHALL be low iff V_VISIBLE+V_FP <= pixel_y < V_VISIBLE+V_FP+V_SYNC (490..491), and SHALL change only together with pixel_y.
REQ-019 frame_start SHALL be high iff pixel_x=0 and pixel_y=0, i.e. for PIX_DIV clk_100 cycles per frame.
REQ-020 Counter widths SHALL be 10 bits; parameters giving H_TOTAL or V_TOTAL > 1024 are unsupported.

Reset
REQ-021 While rst=0, every counter SHALL be 0, with pixel_x=0, pixel_y=0, pix_tick=0, video_on=1, frame_start=1, hsync=1 and vsync=1, asynchronously.
REQ-022 After rst deasserts, the first pix_tick SHALL occur on the PIX_DIV-th rising edge.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, and scanning SHALL restart from (0,0) on release, with no partial sync pulse retained.

Structure
REQ-024 A shared package vga_pkg SHALL hold the 640x480@60 timing constants, the derived H_TOTAL/V_TOTAL and the 10-bit coordinate width; the parameters SHALL default from it.
REQ-025 The pixel-enable divider SHALL be one sub-module, pix_div, with ports clk_100, rst and pix_tick; the h/v counters and decode SHALL live in hvsync_gen.

Verification
REQ-026 Release reset at t=300 ns -> pix_tick pulses every 4 clk_100 cycles, first on the 4th edge; pixel_x steps 0,1,2...
REQ-027 Run one line -> pixel_x wraps 799->0 after 3200 clk_100 cycles; hsync falls at pixel_x=656 and stays low 96 ticks (384 clk_100 cycles).
REQ-028 Check the video_on boundaries -> video_on falls at pixel_x=640, rises at 0 on lines 0..479, and stays low for all of lines 480..524.
REQ-029 Run a full frame -> vsync is low exactly for lines 490 and 491 (1600 ticks); frame_start recurs every 420000 ticks (1,680,000 clk_100 cycles, 16.8 ms).
REQ-030 Assert rst mid-line at pixel (300,200) -> all outputs take their reset values without waiting for a clock edge; after release, scanning resumes from (0,0).
REQ-031 Run a bench with a small override (H 8/2/2/2, V 4/1/1/1) -> H_TOTAL=14 and V_TOTAL=7 wraps, and the sync windows follow REQ-017/018.
